// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: opcode, instruction field positions, dispatch FSM encoding.
package gemm_pkg;

  localparam logic [2:0] OPC_GEMM = 3'b010;

  localparam int OPC_LO      = 0;
  localparam int OPC_HI      = 2;
  localparam int RST_BIT     = 7;
  localparam int UOP_BGN_LO  = 8;
  localparam int UOP_BGN_HI  = 20;
  localparam int UOP_END_LO  = 21;
  localparam int UOP_END_HI  = 34;
  localparam int ITER_OUT_LO = 35;
  localparam int ITER_OUT_HI = 48;
  localparam int ITER_IN_LO  = 49;
  localparam int ITER_IN_HI  = 62;

  localparam int UOP_BGN_W = UOP_BGN_HI - UOP_BGN_LO + 1;
  localparam int CNT_W     = UOP_END_HI - UOP_END_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gemm_state_t;

  typedef struct packed {
    logic [UOP_BGN_W-1:0] uop_bgn;
    logic [CNT_W-1:0]     uop_end;
    logic [CNT_W-1:0]     iter_out;
    logic [CNT_W-1:0]     iter_in;
  } gemm_loop_t;

  // A loop nest with any empty dimension produces no core cycles at all.
  function automatic logic loop_empty(gemm_loop_t f);
    return ({1'b0, f.uop_bgn} >= f.uop_end) || (f.iter_out == '0) || (f.iter_in == '0);
  endfunction

  function automatic logic [CNT_W-1:0] uop_len(gemm_loop_t f);
    return f.uop_end - {1'b0, f.uop_bgn};
  endfunction

endpackage

// File: rtl/insn_fifo.sv
// Instruction queue with occupancy count; storage itself is never reset.
module insn_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/gemm_insn_dispatch.sv
// Queues GEMM instructions and sequences each through RUN (nested uop/iter loops),
// pipeline DRAIN and a DONE pulse; non-GEMM instructions are dropped with err_opcode.
module gemm_insn_dispatch
  import gemm_pkg::*;
#(
  parameter int INS_WIDTH    = 128,
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INS_WIDTH-1:0]          insn_in,
  input  logic                          insn_valid,
  output logic                          insn_ready,
  output logic [INS_WIDTH-1:0]          core_insn,
  output logic                          core_start,
  output logic                          busy,
  output logic                          done,
  output logic                          err_opcode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  gemm_state_t          state, state_nxt;
  logic [INS_WIDTH-1:0] head;
  logic [INS_WIDTH-1:0] insn_q;
  logic                 push, pop;
  gemm_loop_t           hd;
  logic                 hd_gemm, hd_empty, issue;
  logic [CNT_W-1:0]     len_q, in_q, out_q;
  logic [CNT_W-1:0]     uop_cnt, in_cnt, out_cnt;
  logic [DW-1:0]        drn_cnt;
  logic                 last_uop, last_in, last_out, run_last, drn_last;
  logic                 start_q, err_q;

  assign insn_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push       = insn_valid && insn_ready;
  assign pop        = (state == ST_IDLE) && (fifo_count != '0);

  insn_fifo #(
    .WIDTH (INS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (insn_in),
    .rdata (head),
    .count (fifo_count)
  );

  assign hd = '{
    uop_bgn:  head[UOP_BGN_HI:UOP_BGN_LO],
    uop_end:  head[UOP_END_HI:UOP_END_LO],
    iter_out: head[ITER_OUT_HI:ITER_OUT_LO],
    iter_in:  head[ITER_IN_HI:ITER_IN_LO]
  };
  assign hd_gemm  = (head[OPC_HI:OPC_LO] == OPC_GEMM);
  assign hd_empty = loop_empty(hd);
  assign issue    = pop && hd_gemm && !hd_empty;

  assign last_uop = (uop_cnt == len_q - CNT_W'(1));
  assign last_in  = (in_cnt  == in_q  - CNT_W'(1));
  assign last_out = (out_cnt == out_q - CNT_W'(1));
  assign run_last = last_uop && last_in && last_out;
  assign drn_last = (drn_cnt == DW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    core_insn  = '0;
    core_start = start_q;
    err_opcode = err_q;
    case (state)
      ST_IDLE: begin
        if (pop && hd_gemm) state_nxt = hd_empty ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        core_insn = insn_q;
        if (run_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drn_last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Loop nest: uop innermost, then iter_in, then iter_out; the RUN exit is the
  // cycle all three sit on their last value, so no product is ever formed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insn_q  <= '0;
      len_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
      uop_cnt <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      drn_cnt <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= issue;
      err_q   <= pop && !hd_gemm;
      if (issue) begin
        insn_q  <= head;
        len_q   <= uop_len(hd);
        in_q    <= hd.iter_in;
        out_q   <= hd.iter_out;
        uop_cnt <= '0;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else if (state == ST_RUN) begin
        if (!last_uop) begin
          uop_cnt <= uop_cnt + CNT_W'(1);
        end else begin
          uop_cnt <= '0;
          if (!last_in) begin
            in_cnt <= in_cnt + CNT_W'(1);
          end else begin
            in_cnt  <= '0;
            out_cnt <= out_cnt + CNT_W'(1);
          end
        end
      end
      if (state == ST_DRAIN) drn_cnt <= drn_cnt + DW'(1);
      else                   drn_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_gemm_insn_dispatch.sv
// Bench for gemm_insn_dispatch: vector table, hand sequences, and randomized traffic
// checked by a transaction-level model of issue order, RUN length and drain gap.
module tb_gemm_insn_dispatch;

  localparam int W  = 128;
  localparam int D  = 4;
  localparam int DR = 4;
  localparam int CW = 3;

  localparam int K_ERR   = 0;
  localparam int K_EMPTY = 1;
  localparam int K_RUN   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  insn_in = '0;
  logic          insn_valid = 1'b0;
  logic          insn_ready;
  logic [W-1:0]  core_insn;
  logic          core_start, busy, done, err_opcode;
  logic [CW-1:0] fifo_count;

  gemm_insn_dispatch #(
    .INS_WIDTH    (W),
    .FIFO_DEPTH   (D),
    .DRAIN_CYCLES (DR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .insn_in    (insn_in),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .core_insn  (core_insn),
    .core_start (core_start),
    .busy       (busy),
    .done       (done),
    .err_opcode (err_opcode),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [2:0] op, input int bgn, input int en,
                                      input int ot, input int it);
    logic [W-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[2:0]   = op;
    w[20:8]  = 13'(bgn);
    w[34:21] = 14'(en);
    w[48:35] = 14'(ot);
    w[62:49] = 14'(it);
    return w;
  endfunction

  // Reference: RUN length is just the loop-nest product; empty loops skip the core.
  function automatic int run_len(input logic [W-1:0] w);
    int b, e, o, i;
    b = int'(w[20:8]);
    e = int'(w[34:21]);
    o = int'(w[48:35]);
    i = int'(w[62:49]);
    return (e > b) ? (e - b) * o * i : 0;
  endfunction

  function automatic int kind_of(input logic [W-1:0] w);
    if (w[2:0] != 3'b010) return K_ERR;
    if (run_len(w) == 0)  return K_EMPTY;
    return K_RUN;
  endfunction

  function automatic logic [W-1:0] rand_insn();
    logic [2:0] op;
    op = ($urandom_range(0, 9) < 7) ? 3'b010 : 3'($urandom_range(0, 7));
    return mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endfunction

  typedef struct {
    logic [W-1:0] insn;
    int           kind;
    int           len;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_insn(input logic [W-1:0] w);
    exp_t e;
    e.insn = w;
    e.kind = kind_of(w);
    e.len  = run_len(w);
    exp_q.push_back(e);
  endtask

  // Transaction monitor: matches each observed start/err/empty-done to the next
  // queued instruction, measures RUN length and the RUN-end-to-done gap.
  bit           mon_en    = 1'b0;
  bit           in_run    = 1'b0;
  bit           wait_done = 1'b0;
  int           run_cnt, drn, cur_len;
  logic [W-1:0] cur_insn;

  always @(negedge clk) begin
    exp_t e;
    bit   used;
    used = 1'b0;
    if (!mon_en) begin
      in_run    = 1'b0;
      wait_done = 1'b0;
    end else begin
      if (in_run) begin
        if (core_insn === cur_insn && !core_start) begin
          run_cnt++;
        end else begin
          chk("mon_run_len", W'(run_cnt), W'(cur_len));
          chk("mon_drain_insn_zero", core_insn, '0);
          in_run    = 1'b0;
          wait_done = 1'b1;
          drn       = 1;
        end
      end else if (wait_done) begin
        drn++;
        if (done) begin
          chk("mon_done_gap", W'(drn), W'(DR + 1));
          wait_done = 1'b0;
          used      = 1'b1;
        end else if (drn > DR + 1) begin
          chk("mon_done_missing", '0, W'(1));
          wait_done = 1'b0;
        end
      end
      if (core_start) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_start", W'(1), '0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind_start", W'(K_RUN), W'(e.kind));
          chk("mon_issue_insn", core_insn, e.insn);
          cur_insn = core_insn;
          cur_len  = e.len;
          run_cnt  = 1;
          in_run   = 1'b1;
        end
      end
      if (err_opcode) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_err", W'(1), '0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind_err", W'(K_ERR), W'(e.kind));
        end
      end
      if (done && !used) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_done", W'(1), '0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind_empty", W'(K_EMPTY), W'(e.kind));
        end
      end
    end
  end

  task automatic wait_model_idle(input string nm);
    for (int i = 0; i < 5000 && (exp_q.size() != 0 || in_run || wait_done); i++) tick();
    chk(nm, W'(exp_q.size() != 0 || in_run || wait_done), '0);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 500 && busy; i++) tick();
    chk(nm, W'(busy), '0);
  endtask

  typedef struct {
    logic [2:0] op;
    int bgn, en, ot, it;
    bit e_err, e_start, e_empty;
    int e_run;
  } vec_t;

  localparam int NV = 11;
  vec_t vt[NV];

  initial begin
    logic [W-1:0] w, a, f;
    int cnt, d;
    bit bad;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w, a, f;
    int cnt, d;
    bit bad;

    vt[0]  = '{3'b010, 0, 2, 2, 3, 1'b0, 1'b1, 1'b0, 12};
    vt[1]  = '{3'b000, 0, 2, 1, 1, 1'b1, 1'b0, 1'b0, 0};
    vt[2]  = '{3'b010, 0, 2, 2, 0, 1'b0, 1'b0, 1'b1, 0};
    vt[3]  = '{3'b010, 3, 3, 1, 1, 1'b0, 1'b0, 1'b1, 0};
    vt[4]  = '{3'b010, 5, 4, 1, 1, 1'b0, 1'b0, 1'b1, 0};
    vt[5]  = '{3'b010, 0, 1, 0, 2, 1'b0, 1'b0, 1'b1, 0};
    vt[6]  = '{3'b010, 1, 4, 1, 2, 1'b0, 1'b1, 1'b0, 6};
    vt[7]  = '{3'b010, 7, 8, 1, 1, 1'b0, 1'b1, 1'b0, 1};
    vt[8]  = '{3'b111, 0, 3, 1, 1, 1'b1, 1'b0, 1'b0, 0};
    vt[9]  = '{3'b010, 0, 3, 3, 1, 1'b0, 1'b1, 1'b0, 9};
    vt[10] = '{3'b011, 1, 2, 1, 1, 1'b1, 1'b0, 1'b0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_start", W'(core_start), '0);
    chk("rst_err", W'(err_opcode), '0);
    chk("rst_core_insn", core_insn, '0);
    chk("rst_count", W'(fifo_count), '0);
    chk("rst_ready", W'(insn_ready), W'(1));
    rst = 1'b0;
    tick();

    // Single-instruction vector table
    for (int t = 0; t < NV; t++) begin
      w = mk(vt[t].op, vt[t].bgn, vt[t].en, vt[t].ot, vt[t].it);
      insn_in = w;
      insn_valid = 1'b1;
      tick();
      insn_valid = 1'b0;
      chk($sformatf("v%0d_count_push", t), W'(fifo_count), W'(1));
      tick();
      chk($sformatf("v%0d_count_pop", t), W'(fifo_count), '0);
      chk($sformatf("v%0d_start", t), W'(core_start), W'(vt[t].e_start));
      chk($sformatf("v%0d_err", t), W'(err_opcode), W'(vt[t].e_err));
      chk($sformatf("v%0d_done", t), W'(done), W'(vt[t].e_empty));
      chk($sformatf("v%0d_busy", t), W'(busy), W'(vt[t].e_start | vt[t].e_empty));
      chk($sformatf("v%0d_core_insn", t), core_insn, vt[t].e_start ? w : '0);
      if (vt[t].e_start) begin
        cnt = 1;
        bad = 1'b0;
        for (int i = 0; i < 2000; i++) begin
          tick();
          if (core_insn !== w) break;
          if (core_start) bad = 1'b1;
          cnt++;
        end
        chk($sformatf("v%0d_run_len", t), W'(cnt), W'(vt[t].e_run));
        chk($sformatf("v%0d_start_once", t), W'(bad), '0);
        chk($sformatf("v%0d_drain_zero", t), core_insn, '0);
        chk($sformatf("v%0d_drain_busy", t), W'(busy), W'(1));
        d = 1;
        for (int i = 0; i < 20 && !done; i++) begin
          tick();
          d++;
        end
        chk($sformatf("v%0d_done_gap", t), W'(d), W'(DR + 1));
      end
      tick();
      chk($sformatf("v%0d_post_done", t), W'(done), '0);
      chk($sformatf("v%0d_post_busy", t), W'(busy), '0);
      chk($sformatf("v%0d_post_err", t), W'(err_opcode), '0);
      chk($sformatf("v%0d_post_start", t), W'(core_start), '0);
    end

    // Fill the queue behind a long RUN; the 5th push waits for a pop
    mon_en = 1'b1;
    a = mk(3'b010, 0, 4, 4, 4);
    insn_in = a; insn_valid = 1'b1; expect_insn(a);
    tick();
    insn_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      w = mk(3'b010, 0, 1 + (i % 2), 1, 1);
      insn_in = w; insn_valid = 1'b1; expect_insn(w);
      tick();
    end
    chk("full_count", W'(fifo_count), W'(D));
    chk("full_ready", W'(insn_ready), '0);
    f = mk(3'b010, 2, 3, 1, 1);
    insn_in = f;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (insn_ready || fifo_count != CW'(D)) bad = 1'b1;
    end
    chk("full_hold", W'(bad), '0);
    for (int i = 0; i < 300 && !insn_ready; i++) tick();
    chk("full_ready_timeout", W'(insn_ready), W'(1));
    expect_insn(f);
    tick();
    insn_valid = 1'b0;
    chk("full_refill_count", W'(fifo_count), W'(D));
    wait_model_idle("full_order_drain");
    wait_idle("full_idle");

    // Push and pop on the same edge at count 2
    a = mk(3'b010, 0, 3, 2, 1);
    insn_in = a; insn_valid = 1'b1; expect_insn(a);
    tick();
    insn_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      w = mk(3'b010, 0, 2, 1, 1);
      insn_in = w; insn_valid = 1'b1; expect_insn(w);
      tick();
    end
    insn_valid = 1'b0;
    chk("pp_count_pre", W'(fifo_count), W'(2));
    wait_idle("pp_wait_idle");
    w = mk(3'b010, 1, 2, 1, 1);
    insn_in = w; insn_valid = 1'b1; expect_insn(w);
    tick();
    insn_valid = 1'b0;
    chk("pp_count_same", W'(fifo_count), W'(2));
    chk("pp_start", W'(core_start), W'(1));
    wait_model_idle("pp_order_drain");
    wait_idle("pp_idle");

    // Reset mid-RUN with two queued entries
    mon_en = 1'b0;
    tick();
    a = mk(3'b010, 0, 4, 4, 4);
    insn_in = a; insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      insn_in = mk(3'b010, 0, 1, 1, 1); insn_valid = 1'b1;
      tick();
    end
    insn_valid = 1'b0;
    tick();
    tick();
    chk("mr_count_pre", W'(fifo_count), W'(2));
    chk("mr_in_run", core_insn, a);
    rst = 1'b1;
    #1;
    chk("mr_core_insn", core_insn, '0);
    chk("mr_busy", W'(busy), '0);
    chk("mr_start", W'(core_start), '0);
    chk("mr_done", W'(done), '0);
    chk("mr_err", W'(err_opcode), '0);
    chk("mr_count", W'(fifo_count), '0);
    chk("mr_ready", W'(insn_ready), W'(1));
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || core_start || busy || err_opcode) bad = 1'b1;
    end
    chk("mr_quiet", W'(bad), '0);
    w = mk(3'b010, 1, 3, 1, 1);
    insn_in = w; insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    tick();
    chk("mr_next_start", W'(core_start), W'(1));
    chk("mr_next_insn", core_insn, w);
    wait_idle("mr_idle");

    // Randomized traffic against the transaction model
    mon_en = 1'b1;
    tick();
    for (int n = 0; n < 40; ) begin
      if (insn_ready && $urandom_range(0, 2) != 0) begin
        w = rand_insn();
        insn_in = w;
        insn_valid = 1'b1;
        expect_insn(w);
        n++;
      end else begin
        insn_valid = 1'b0;
      end
      tick();
    end
    insn_valid = 1'b0;
    wait_model_idle("rand_drain");
    wait_idle("rand_idle");
    chk("rand_count_empty", W'(fifo_count), '0);
    mon_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
